// File: rtl/fp_reg_scoreboard_if.sv
// Issue, writeback and execute-stage signals between the FP issue logic,
// the register scoreboard and the FP ALU.
interface fp_reg_scoreboard_if #(
    parameter int AW = 5
);
    logic          issue_valid;
    logic          issue_ready;
    logic [3:0]    issue_ctrl;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [AW-1:0] rd_addr;
    logic          issue_uses_rs2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_data;
    logic          ex_stall;
    logic          ex_valid;
    logic [31:0]   ex_a;
    logic [31:0]   ex_b;
    logic [3:0]    ex_ctrl;
    logic [AW-1:0] ex_rd;

    // Upstream side: presents ops and writebacks, observes the execute stage.
    modport master (
        output issue_valid, issue_ctrl, rs1_addr, rs2_addr, rd_addr, issue_uses_rs2,
        output wb_en, wb_addr, wb_data, ex_stall,
        input  issue_ready, ex_valid, ex_a, ex_b, ex_ctrl, ex_rd
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_ctrl, rs1_addr, rs2_addr, rd_addr, issue_uses_rs2,
        input  wb_en, wb_addr, wb_data, ex_stall,
        output issue_ready, ex_valid, ex_a, ex_b, ex_ctrl, ex_rd
    );
endinterface

// File: rtl/fp_reg_scoreboard.sv
// FP register file with a per-register busy scoreboard. Ops are held at issue
// until their sources and destination are free (a same-cycle writeback counts
// as free), then their operands are registered into the execute stage.
module fp_reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5
) (
    input logic                clk,
    input logic                rst,
    fp_reg_scoreboard_if.slave bus
);
    logic [31:0]         regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic          hit1, hit2, hitd;
    logic          raw1, raw2, waw;
    logic          ready;
    logic          accept;
    logic [31:0]   op_a, op_b;

    logic          ex_valid_q;
    logic [31:0]   ex_a_q, ex_b_q;
    logic [3:0]    ex_ctrl_q;
    logic [AW-1:0] ex_rd_q;

    // Operand read with writeback bypass, hazard detection and handshake.
    always_comb begin
        hit1   = bus.wb_en && (bus.wb_addr == bus.rs1_addr);
        hit2   = bus.wb_en && (bus.wb_addr == bus.rs2_addr);
        hitd   = bus.wb_en && (bus.wb_addr == bus.rd_addr);
        raw1   = busy[bus.rs1_addr] && !hit1;
        raw2   = bus.issue_uses_rs2 && busy[bus.rs2_addr] && !hit2;
        waw    = busy[bus.rd_addr] && !hitd;
        ready  = !bus.ex_stall && !raw1 && !raw2 && !waw;
        accept = bus.issue_valid && ready;
        op_a   = hit1 ? bus.wb_data : regs[bus.rs1_addr];
        op_b   = 32'h0;
        if (bus.issue_uses_rs2) begin
            op_b = hit2 ? bus.wb_data : regs[bus.rs2_addr];
        end
    end

    // Next busy vector: writeback clears first so a same-cycle issue to the same
    // destination leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (bus.wb_en) begin
            busy_next[bus.wb_addr] = 1'b0;
        end
        if (accept) begin
            busy_next[bus.rd_addr] = 1'b1;
        end
    end

    // Register file, scoreboard and execute-stage operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'h0;
            end
            busy       <= '0;
            ex_valid_q <= 1'b0;
            ex_a_q     <= 32'h0;
            ex_b_q     <= 32'h0;
            ex_ctrl_q  <= 4'h0;
            ex_rd_q    <= '0;
        end else begin
            if (bus.wb_en) begin
                regs[bus.wb_addr] <= bus.wb_data;
            end
            busy <= busy_next;
            if (!bus.ex_stall) begin
                ex_valid_q <= accept;
                if (accept) begin
                    ex_a_q    <= op_a;
                    ex_b_q    <= op_b;
                    ex_ctrl_q <= bus.issue_ctrl;
                    ex_rd_q   <= bus.rd_addr;
                end
            end
        end
    end

    assign bus.issue_ready = ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_a        = ex_a_q;
    assign bus.ex_b        = ex_b_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_rd       = ex_rd_q;
endmodule

// File: tb/tb_fp_reg_scoreboard.sv
// Bench for fp_reg_scoreboard: directed scenarios with literal expectations,
// then randomized traffic against a behavioural register/busy model.
module tb_fp_reg_scoreboard;
    logic clk;
    logic rst;

    fp_reg_scoreboard_if #(.AW(5)) bus ();

    fp_reg_scoreboard #(.NUM_REGS(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic        m_ex_valid;
    logic [31:0] m_ex_a, m_ex_b;
    logic [3:0]  m_ex_ctrl;
    logic [4:0]  m_ex_rd;

    int   n_vectors;
    int   n_checks;
    int   n_miscompares;
    logic seen_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (vector %0d)", name, act, exp, n_vectors);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] a);
        return m_busy[a] && !(bus.wb_en && bus.wb_addr == a);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (bus.wb_en && bus.wb_addr == a) ? bus.wb_data : m_regs[a];
    endfunction

    function automatic logic m_ready();
        return !bus.ex_stall && !m_pending(bus.rs1_addr)
               && !(bus.issue_uses_rs2 && m_pending(bus.rs2_addr))
               && !m_pending(bus.rd_addr);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic        acc;
        logic [31:0] a, b;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_ex_valid = 1'b0;
            m_ex_a = 32'h0;
            m_ex_b = 32'h0;
            m_ex_ctrl = 4'h0;
            m_ex_rd = 5'h0;
        end else begin
            acc = bus.issue_valid && m_ready();
            a = m_read(bus.rs1_addr);
            b = bus.issue_uses_rs2 ? m_read(bus.rs2_addr) : 32'h0;
            if (bus.wb_en) begin
                m_regs[bus.wb_addr] = bus.wb_data;
                m_busy[bus.wb_addr] = 1'b0;
            end
            if (acc) m_busy[bus.rd_addr] = 1'b1;
            if (!bus.ex_stall) begin
                m_ex_valid = acc;
                if (acc) begin
                    m_ex_a = a;
                    m_ex_b = b;
                    m_ex_ctrl = bus.issue_ctrl;
                    m_ex_rd = bus.rd_addr;
                end
            end
        end
    endtask

    // One cycle: inputs are already set at the falling edge; check the
    // handshake before the rising edge and the execute stage after it.
    task automatic checkOutput();
        #1;
        seen_ready = bus.issue_ready;
        check("issue_ready", {31'h0, bus.issue_ready}, {31'h0, m_ready()});
        @(posedge clk);
        model_edge();
        #1;
        check("ex_valid", {31'h0, bus.ex_valid}, {31'h0, m_ex_valid});
        check("ex_a", bus.ex_a, m_ex_a);
        check("ex_b", bus.ex_b, m_ex_b);
        check("ex_ctrl", {28'h0, bus.ex_ctrl}, {28'h0, m_ex_ctrl});
        check("ex_rd", {27'h0, bus.ex_rd}, {27'h0, m_ex_rd});
        @(negedge clk);
        n_vectors++;
    endtask

    task automatic set_idle();
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = 4'h0;
        bus.rs1_addr = 5'h0;
        bus.rs2_addr = 5'h0;
        bus.rd_addr = 5'h0;
        bus.issue_uses_rs2 = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_addr = 5'h0;
        bus.wb_data = 32'h0;
        bus.ex_stall = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic u2, input logic [3:0] ctrl);
        bus.issue_valid = 1'b1;
        bus.rs1_addr = r1;
        bus.rs2_addr = r2;
        bus.rd_addr = rd;
        bus.issue_uses_rs2 = u2;
        bus.issue_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        checkOutput();
        rst = 1'b0;
    endtask

    // Random traffic biased toward a few registers to provoke hazards.
    task automatic applyStimulus();
        logic [4:0] cand;
        set_idle();
        rst = ($urandom_range(0, 99) < 2);
        bus.ex_stall = ($urandom_range(0, 99) < 20);
        bus.issue_valid = ($urandom_range(0, 99) < 70);
        bus.issue_ctrl = 4'($urandom);
        bus.rs1_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        bus.rs2_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        bus.rd_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        bus.issue_uses_rs2 = ($urandom_range(0, 3) != 0);
        bus.wb_en = ($urandom_range(0, 99) < 50);
        bus.wb_data = $urandom;
        bus.wb_addr = 5'($urandom_range(0, 7));
        for (int t = 0; t < 4; t++) begin
            cand = 5'($urandom_range(0, 7));
            if (m_busy[cand]) bus.wb_addr = cand;
        end
    endtask

    initial begin
        n_vectors = 0;
        n_checks = 0;
        n_miscompares = 0;
        set_idle();
        @(negedge clk);

        // Writeback then issue reading it through the register file.
        do_reset();
        set_idle(); set_wb(5'd3, 32'h3F800000); checkOutput();
        set_idle(); set_issue(5'd3, 5'd3, 5'd5, 1'b1, 4'h0); checkOutput();
        check("lit_ex_valid", {31'h0, bus.ex_valid}, 32'h1);
        check("lit_ex_a", bus.ex_a, 32'h3F800000);
        check("lit_ex_b", bus.ex_b, 32'h3F800000);
        check("lit_ex_rd", {27'h0, bus.ex_rd}, 32'd5);
        set_idle(); set_issue(5'd0, 5'd0, 5'd5, 1'b1, 4'h1); checkOutput();
        check("lit_waw_blocked", {31'h0, seen_ready}, 32'h0);

        // RAW on a busy source, released by a same-cycle writeback.
        set_idle(); set_issue(5'd5, 5'd0, 5'd6, 1'b1, 4'h2); checkOutput();
        check("lit_raw_blocked", {31'h0, seen_ready}, 32'h0);
        set_idle(); set_issue(5'd5, 5'd0, 5'd6, 1'b1, 4'h2); set_wb(5'd5, 32'h40000000); checkOutput();
        check("lit_raw_bypass_ready", {31'h0, seen_ready}, 32'h1);
        check("lit_raw_bypass_a", bus.ex_a, 32'h40000000);

        // Issue and writeback to the same destination leave it busy.
        set_idle(); set_issue(5'd0, 5'd0, 5'd7, 1'b1, 4'h3); checkOutput();
        set_idle(); set_issue(5'd1, 5'd1, 5'd7, 1'b1, 4'h3); set_wb(5'd7, 32'h12345678); checkOutput();
        check("lit_set_wins_ready", {31'h0, seen_ready}, 32'h1);
        set_idle(); set_issue(5'd2, 5'd2, 5'd7, 1'b1, 4'h3); checkOutput();
        check("lit_set_wins_busy", {31'h0, seen_ready}, 32'h0);

        // Execute stall holds the stage; the waiting op goes on release.
        do_reset();
        set_idle(); set_issue(5'd1, 5'd2, 5'd4, 1'b1, 4'hA); checkOutput();
        for (int k = 0; k < 3; k++) begin
            set_idle(); bus.ex_stall = 1'b1; set_issue(5'd2, 5'd3, 5'd8, 1'b1, 4'hB); checkOutput();
            check("lit_stall_ready", {31'h0, seen_ready}, 32'h0);
            check("lit_stall_valid", {31'h0, bus.ex_valid}, 32'h1);
            check("lit_stall_rd", {27'h0, bus.ex_rd}, 32'd4);
            check("lit_stall_ctrl", {28'h0, bus.ex_ctrl}, 32'hA);
        end
        set_idle(); set_issue(5'd2, 5'd3, 5'd8, 1'b1, 4'hB); checkOutput();
        check("lit_release_ready", {31'h0, seen_ready}, 32'h1);
        check("lit_release_rd", {27'h0, bus.ex_rd}, 32'd8);
        check("lit_release_ctrl", {28'h0, bus.ex_ctrl}, 32'hB);

        // Single-source op ignores a busy rs2 and presents ex_b = 0.
        set_idle(); set_wb(5'd9, 32'hCAFEF00D); checkOutput();
        set_idle(); set_issue(5'd0, 5'd0, 5'd9, 1'b1, 4'h0); checkOutput();
        set_idle(); set_issue(5'd1, 5'd9, 5'd10, 1'b0, 4'h5); checkOutput();
        check("lit_no_rs2_ready", {31'h0, seen_ready}, 32'h1);
        check("lit_no_rs2_b", bus.ex_b, 32'h0);

        // Reset while busy and valid, with an op and writeback presented.
        set_idle(); set_wb(5'd12, 32'hDEADBEEF); set_issue(5'd12, 5'd12, 5'd11, 1'b1, 4'h6); checkOutput();
        set_idle(); rst = 1'b1; set_issue(5'd1, 5'd2, 5'd13, 1'b1, 4'h7); set_wb(5'd14, 32'h11111111);
        checkOutput();
        check("lit_rst_valid", {31'h0, bus.ex_valid}, 32'h0);
        check("lit_rst_a", bus.ex_a, 32'h0);
        check("lit_rst_rd", {27'h0, bus.ex_rd}, 32'h0);
        set_idle(); set_issue(5'd12, 5'd14, 5'd9, 1'b1, 4'h1); checkOutput();
        check("lit_post_rst_ready", {31'h0, seen_ready}, 32'h1);
        check("lit_post_rst_a", bus.ex_a, 32'h0);
        check("lit_post_rst_b", bus.ex_b, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/fp_reg_scoreboard.md
FP_REG_SCOREBOARD -- requirements
Module: fp_reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of FP architectural registers f0..f31.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1  upstream presents an FP op.
REQ-006 SHALL have port issue_ready  output  1  op accepted this cycle when high with issue_valid.
REQ-007 SHALL have port issue_ctrl  input  4  ALU control code, passed through unchanged.
REQ-008 SHALL have ports rs1_addr, rs2_addr, rd_addr  input  AW each  source and destination register addresses.
REQ-009 SHALL have port issue_uses_rs2  input  1  op reads rs2 (low for class/convert ops).
REQ-010 SHALL have ports wb_en  input  1, wb_addr  input  AW, wb_data  input  32  writeback from the ALU result path.
REQ-011 SHALL have port ex_stall  input  1  execute stage cannot advance.
REQ-012 SHALL have ports ex_valid  output  1, ex_a  output  32, ex_b  output  32, ex_ctrl  output  4, ex_rd  output  AW  registered operands to the FP ALU.

Function
REQ-013 SHALL hold NUM_REGS x 32-bit registers; f0 is a normal writable register.
REQ-014 SHALL hold one busy bit per register, set = result pending.
REQ-015 SHALL write wb_data to reg[wb_addr] and clear busy[wb_addr] on the edge where wb_en=1.
REQ-016 SHALL read operands combinationally with write-through bypass: if wb_en and wb_addr equals a source address, that operand is wb_data.
REQ-017 SHALL define raw1 = busy[rs1_addr] and not (wb_en and wb_addr==rs1_addr).
REQ-018 SHALL define raw2 = issue_uses_rs2 and busy[rs2_addr] and not (wb_en and wb_addr==rs2_addr).
REQ-019 SHALL define waw = busy[rd_addr] and not (wb_en and wb_addr==rd_addr).
REQ-020 SHALL drive issue_ready = not ex_stall and not raw1 and not raw2 and not waw, combinationally; it does not depend on issue_valid.
REQ-021 SHALL accept an op when issue_valid and issue_ready; on that edge load ex_a, ex_b, ex_ctrl, ex_rd, set ex_valid=1, set busy[rd_addr].
REQ-022 SHALL give the set priority over the writeback clear when an accepted rd_addr equals wb_addr in the same cycle; the busy bit ends set.
REQ-023 SHALL, when ex_stall=1, hold all ex_* outputs unchanged; writebacks still update the registers and busy bits.
REQ-024 SHALL, when ex_stall=0 and no op is accepted, clear ex_valid and hold ex_a/ex_b/ex_ctrl/ex_rd.
REQ-025 SHALL give issue-to-ex latency of exactly one cycle with no bubble between back-to-back independent ops.
REQ-026 SHALL present ex_b = 0 when issue_uses_rs2=0 at acceptance.
REQ-027 SHALL ignore issue_* inputs when issue_valid=0; busy bits change only through REQ-015 and REQ-021.

Reset
REQ-028 SHALL, on a clock edge with rst=1, clear all registers to 0, clear all busy bits, and drive ex_valid=0, ex_a=0, ex_b=0, ex_ctrl=0, ex_rd=0.
REQ-029 SHALL give rst priority over simultaneous issue and writeback; ops presented during reset are dropped.
REQ-030 SHALL drive issue_ready=1 in the first cycle after reset deassertion when ex_stall=0.

Verification
REQ-031 SHALL pass this test: after reset, wb f3=0x3F800000, then issue ctrl=0000 rs1=3 rs2=3 rd=5 -> next cycle ex_valid=1, ex_a=ex_b=0x3F800000, ex_rd=5, busy[5]=1.
REQ-032 SHALL pass this test: with busy[5]=1, issue with rs1=5 -> issue_ready=0. Then wb_en=1 wb_addr=5 wb_data=0x40000000 in the same cycle -> issue_ready=1 and ex_a=0x40000000.
REQ-033 SHALL pass this test: accept rd=7 while wb_addr=7 in the same cycle -> busy[7]=1 afterwards; a following issue writing rd=7 stalls.
REQ-034 SHALL pass this test: ex_stall=1 for 3 cycles with a valid ex op -> ex_* stable and issue_ready=0; on release, the pending op is accepted on the next edge.
REQ-035 SHALL pass this test: issue_uses_rs2=0 with busy[rs2_addr]=1 -> accepted and ex_b=0.
REQ-036 SHALL pass this test: rst=1 asserted while ex_valid=1 and busy bits are set -> next cycle ex_valid=0, all busy=0, reading any register gives 0x00000000.
